// File: rtl/game_update_hist_pkg.sv
// Purpose: shared game encoding (PLAY/DRAW codes, width helper, edge action decode) for game_update_hist.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package game_update_hist_pkg;

  // Cell value 0 means empty; curr_state 0 means the game is still being played.
  localparam int PLAY_CODE = 0;

  // Ceiling log2; clog2(1) = 0. Used for every derived width so the judge and
  // display logic agree on the cell/turn/state encoding.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // DRAW is the all-ones code of a state field of the given width.
  function automatic int draw_code(input int sw);
    return (1 << sw) - 1;
  endfunction

  // What a single confirm edge does, after priority resolution.
  typedef enum logic [1:0] {
    ACT_HOLD     = 2'd0,
    ACT_NEW_GAME = 2'd1,
    ACT_UNDO     = 2'd2,
    ACT_COMMIT   = 2'd3
  } action_e;

endpackage

// File: rtl/game_update_hist_stack.sv
// Purpose: circular LIFO of boards for undo; a push when full overwrites the oldest entry.
// Latency: push/pop/clear take effect on the clock edge; top_dat is the newest entry, read combinationally.
// Backpressure: none; pop with level 0 is ignored, push when full keeps level at DEPTH.
module move_history_stack
  import game_update_hist_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int LVL_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top_dat,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;      // slot holding the newest entry
  logic [PTR_W-1:0] head_inc;
  logic [PTR_W-1:0] head_dec;
  logic             do_push;
  logic             do_pop;

  // Clear wins over push/pop; pop of an empty stack does nothing.
  assign do_push  = push && !clear;
  assign do_pop   = pop && !clear && !push && (level != '0);
  assign head_inc = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
  assign head_dec = (head == '0) ? PTR_W'(DEPTH - 1) : head - PTR_W'(1);
  assign top_dat  = mem[head];

  // Ring pointer and occupancy; level saturates at DEPTH when overwriting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      level <= '0;
    end else if (clear) begin
      head  <= '0;
      level <= '0;
    end else if (do_push) begin
      head  <= head_inc;
      level <= (level == LVL_W'(DEPTH)) ? level : level + LVL_W'(1);
    end else if (do_pop) begin
      head  <= head_dec;
      level <= level - LVL_W'(1);
    end
  end

  // Board storage; contents are only meaningful below level, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[head_inc] <= din;
  end

endmodule

// File: rtl/game_update_hist.sv
// Purpose: board/turn/state register for N-player grid games with a bounded undo history.
// Latency: every output is registered and changes on the OK_button rising edge that commits the action.
// Backpressure: none; undo with empty history and idle edges simply hold state.
module game_update_hist
  import game_update_hist_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CELLS       = 9,
  parameter int HIST_DEPTH  = 4,
  localparam int CELL_W = clog2(NUM_PLAYERS + 1),
  localparam int PW     = CELL_W,
  localparam int SW     = clog2(NUM_PLAYERS + 2),
  localparam int BW     = CELLS * CELL_W,
  localparam int CW     = clog2(CELLS + 1),
  localparam int HW     = clog2(HIST_DEPTH + 1)
) (
  input  logic          OK_button,
  input  logic          reset,
  input  logic          valid_move,
  input  logic          undo,
  input  logic [BW-1:0] next_move,
  input  logic [SW-1:0] next_state,
  output logic [BW-1:0] curr_move,
  output logic [SW-1:0] curr_state,
  output logic [PW-1:0] curr_turn,
  output logic [CW-1:0] move_count,
  output logic [HW-1:0] hist_level
);

  localparam logic [SW-1:0] STATE_PLAY = SW'(PLAY_CODE);
  localparam logic [SW-1:0] STATE_DRAW = SW'(draw_code(SW));

  action_e       action;
  logic [BW-1:0] hist_top;
  logic [PW-1:0] turn_next;
  logic [PW-1:0] turn_prev;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_dec;

  // Edge priority: finished game restarts, then undo (even when it cannot pop), then commit.
  always_comb begin
    action = ACT_HOLD;
    if (curr_state != STATE_PLAY) begin
      action = ACT_NEW_GAME;
    end else if (undo) begin
      action = (hist_level != '0) ? ACT_UNDO : ACT_HOLD;
    end else if (valid_move) begin
      action = ACT_COMMIT;
    end
  end

  // Turn rotation wraps over players 1..NUM_PLAYERS; the counter saturates at CELLS and floors at 0.
  assign turn_next = (curr_turn == PW'(NUM_PLAYERS)) ? PW'(1) : curr_turn + PW'(1);
  assign turn_prev = (curr_turn == PW'(1)) ? PW'(NUM_PLAYERS) : curr_turn - PW'(1);
  assign count_inc = (move_count == CW'(CELLS)) ? move_count : move_count + CW'(1);
  assign count_dec = (move_count == '0) ? '0 : move_count - CW'(1);

  move_history_stack #(
    .WIDTH (BW),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (OK_button),
    .rst     (reset),
    .push    (action == ACT_COMMIT),
    .pop     (action == ACT_UNDO),
    .clear   (action == ACT_NEW_GAME),
    .din     (curr_move),
    .top_dat (hist_top),
    .level   (hist_level)
  );

  // Committed game registers; reset parks the game in DRAW so the first confirm starts play.
  always_ff @(posedge OK_button or posedge reset) begin
    if (reset) begin
      curr_move  <= '0;
      curr_state <= STATE_DRAW;
      curr_turn  <= PW'(1);
      move_count <= '0;
    end else begin
      case (action)
        ACT_NEW_GAME: begin
          curr_move  <= '0;
          curr_state <= STATE_PLAY;
          curr_turn  <= PW'(1);
          move_count <= '0;
        end
        ACT_UNDO: begin
          curr_move  <= hist_top;
          curr_state <= STATE_PLAY;
          curr_turn  <= turn_prev;
          move_count <= count_dec;
        end
        ACT_COMMIT: begin
          curr_move  <= next_move;
          curr_state <= next_state;
          curr_turn  <= turn_next;
          move_count <= count_inc;
        end
        ACT_HOLD: begin
          curr_move  <= curr_move;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_update_hist.sv
// Purpose: self-checking bench for game_update_hist (2-player 3x3 and 3-player 16-cell instances).
// Latency: outputs sampled 1 time unit after each OK_button rising edge.
// Backpressure: n/a.
module tb_game_update_hist;

  logic clk;
  logic reset;

  // Instance A: defaults (BW=18, SW=2, PW=2, CW=4, HW=3)
  logic        a_valid, a_undo;
  logic [17:0] a_nmove, a_move;
  logic [1:0]  a_nstate, a_state, a_turn;
  logic [3:0]  a_count;
  logic [2:0]  a_hist;

  // Instance B: 3 players, 16 cells (BW=32, SW=3, PW=2, CW=5, HW=3)
  logic        b_valid, b_undo;
  logic [31:0] b_nmove, b_move;
  logic [2:0]  b_nstate, b_state;
  logic [1:0]  b_turn;
  logic [4:0]  b_count;
  logic [2:0]  b_hist;

  int n_checks;
  int n_pass;

  game_update_hist dut_a (
    .OK_button (clk), .reset (reset), .valid_move (a_valid), .undo (a_undo),
    .next_move (a_nmove), .next_state (a_nstate), .curr_move (a_move),
    .curr_state (a_state), .curr_turn (a_turn), .move_count (a_count), .hist_level (a_hist)
  );

  game_update_hist #(.NUM_PLAYERS(3), .CELLS(16), .HIST_DEPTH(4)) dut_b (
    .OK_button (clk), .reset (reset), .valid_move (b_valid), .undo (b_undo),
    .next_move (b_nmove), .next_state (b_nstate), .curr_move (b_move),
    .curr_state (b_state), .curr_turn (b_turn), .move_count (b_count), .hist_level (b_hist)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step_a(input logic u, input logic v, input logic [17:0] nm, input logic [1:0] ns);
    a_undo = u; a_valid = v; a_nmove = nm; a_nstate = ns;
    @(posedge clk); #1;
    a_undo = 1'b0; a_valid = 1'b0;
  endtask

  task automatic step_b(input logic u, input logic v, input logic [31:0] nm, input logic [2:0] ns);
    b_undo = u; b_valid = v; b_nmove = nm; b_nstate = ns;
    @(posedge clk); #1;
    b_undo = 1'b0; b_valid = 1'b0;
  endtask

  // Pulse reset away from the clock edge.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table for instance A ----------------
  typedef struct {
    logic        undo;
    logic        valid;
    logic [17:0] nmove;
    logic [1:0]  nstate;
    logic [17:0] emove;
    logic [1:0]  estate;
    logic [1:0]  eturn;
    logic [3:0]  ecount;
    logic [2:0]  ehist;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic u, input logic v, input logic [17:0] nm, input logic [1:0] ns,
                         input logic [17:0] em, input logic [1:0] es, input logic [1:0] et,
                         input logic [3:0] ec, input logic [2:0] eh);
    vec_t r;
    r.undo = u; r.valid = v; r.nmove = nm; r.nstate = ns;
    r.emove = em; r.estate = es; r.eturn = et; r.ecount = ec; r.ehist = eh;
    vecs.push_back(r);
  endtask

  // ---------------- behavioural model for randomized runs ----------------
  logic [31:0] m_board;
  int          m_state, m_turn, m_count;
  logic [31:0] m_hist[$];

  task automatic model_reset(input int draw);
    m_board = '0; m_state = draw; m_turn = 1; m_count = 0;
    m_hist.delete();
  endtask

  task automatic model_edge(input int np, input int cells, input int depth,
                            input logic u, input logic v, input logic [31:0] nm, input int ns);
    if (m_state != 0) begin
      model_reset(0);
    end else if (u) begin
      if (m_hist.size() > 0) begin
        m_board = m_hist.pop_back();
        m_turn  = (m_turn == 1) ? np : m_turn - 1;
        m_count = (m_count > 0) ? m_count - 1 : 0;
      end
    end else if (v) begin
      m_hist.push_back(m_board);
      if (m_hist.size() > depth) void'(m_hist.pop_front());
      m_board = nm;
      m_state = ns;
      m_turn  = (m_turn == np) ? 1 : m_turn + 1;
      m_count = (m_count < cells) ? m_count + 1 : cells;
    end
  endtask

  task automatic rand_run(input bit is_b, input int n);
    int np, cells, draw, bw, r, ns;
    logic u, v;
    logic [31:0] nm;
    np    = is_b ? 3 : 2;
    cells = is_b ? 16 : 9;
    draw  = is_b ? 7 : 3;
    bw    = is_b ? 32 : 18;
    do_reset();
    model_reset(draw);
    for (int i = 0; i < n; i++) begin
      u  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 9) < 7);
      nm = $urandom();
      if (bw < 32) nm = nm & ((32'd1 << bw) - 32'd1);
      r  = $urandom_range(0, 19);
      if (r < 17)      ns = 0;
      else if (r < 19) ns = $urandom_range(1, np);
      else             ns = draw;
      model_edge(np, cells, 4, u, v, nm, ns);
      if (is_b) begin
        step_b(u, v, nm, 3'(ns));
        chk("rand_b_move",  b_move, m_board);
        chk("rand_b_state", 32'(b_state), 32'(m_state));
        chk("rand_b_turn",  32'(b_turn),  32'(m_turn));
        chk("rand_b_count", 32'(b_count), 32'(m_count));
        chk("rand_b_hist",  32'(b_hist),  32'(m_hist.size()));
      end else begin
        step_a(u, v, nm[17:0], 2'(ns));
        chk("rand_a_move",  32'(a_move),  m_board);
        chk("rand_a_state", 32'(a_state), 32'(m_state));
        chk("rand_a_turn",  32'(a_turn),  32'(m_turn));
        chk("rand_a_count", 32'(a_count), 32'(m_count));
        chk("rand_a_hist",  32'(a_hist),  32'(m_hist.size()));
      end
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1;
    a_valid = 0; a_undo = 0; a_nmove = '0; a_nstate = '0;
    b_valid = 0; b_undo = 0; b_nmove = '0; b_nstate = '0;

    // Table: idle edge starts a game, T2, T3, T4, T5, draw restart, count saturation.
    add_vec(0, 0, 18'h0,     2'd0, 18'h0,     2'd0, 2'd1, 4'd0, 3'd0);
    add_vec(0, 1, 18'h1,     2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd1);
    add_vec(1, 0, 18'h0,     2'd0, 18'h0,     2'd0, 2'd1, 4'd0, 3'd0);
    add_vec(0, 1, 18'h1,     2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd1);
    add_vec(0, 1, 18'h5,     2'd0, 18'h5,     2'd0, 2'd1, 4'd2, 3'd2);
    add_vec(0, 1, 18'h15,    2'd0, 18'h15,    2'd0, 2'd2, 4'd3, 3'd3);
    add_vec(0, 1, 18'h55,    2'd0, 18'h55,    2'd0, 2'd1, 4'd4, 3'd4);
    add_vec(0, 1, 18'h155,   2'd0, 18'h155,   2'd0, 2'd2, 4'd5, 3'd4);
    add_vec(1, 0, 18'h0,     2'd0, 18'h55,    2'd0, 2'd1, 4'd4, 3'd3);
    add_vec(1, 0, 18'h0,     2'd0, 18'h15,    2'd0, 2'd2, 4'd3, 3'd2);
    add_vec(1, 0, 18'h0,     2'd0, 18'h5,     2'd0, 2'd1, 4'd2, 3'd1);
    add_vec(1, 0, 18'h0,     2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd0);
    add_vec(1, 0, 18'h0,     2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd0);
    add_vec(0, 1, 18'h3,     2'd0, 18'h3,     2'd0, 2'd1, 4'd2, 3'd1);
    add_vec(1, 1, 18'h3FFFF, 2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd0);
    add_vec(1, 1, 18'h3FFFF, 2'd0, 18'h1,     2'd0, 2'd2, 4'd1, 3'd0);
    add_vec(0, 1, 18'h3,     2'd1, 18'h3,     2'd1, 2'd1, 4'd2, 3'd1);
    add_vec(1, 0, 18'h0,     2'd0, 18'h0,     2'd0, 2'd1, 4'd0, 3'd0);
    add_vec(0, 1, 18'h15,    2'd3, 18'h15,    2'd3, 2'd2, 4'd1, 3'd1);
    add_vec(0, 1, 18'h2AAAA, 2'd0, 18'h0,     2'd0, 2'd1, 4'd0, 3'd0);
    for (int k = 1; k <= 10; k++)
      add_vec(0, 1, 18'(k), 2'd0, 18'(k), 2'd0, (k % 2 == 1) ? 2'd2 : 2'd1,
              4'((k < 9) ? k : 9), 3'((k < 4) ? k : 4));

    // T1: reset values, A and B.
    #3;
    reset = 1'b0;
    chk("rst_a_state", 32'(a_state), 32'd3);
    chk("rst_a_turn",  32'(a_turn),  32'd1);
    chk("rst_a_move",  32'(a_move),  32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_a_hist",  32'(a_hist),  32'd0);
    chk("rst_b_state", 32'(b_state), 32'd7);

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].undo, vecs[i].valid, vecs[i].nmove, vecs[i].nstate);
      chk($sformatf("vec%0d_move", i),  32'(a_move),  32'(vecs[i].emove));
      chk($sformatf("vec%0d_state", i), 32'(a_state), 32'(vecs[i].estate));
      chk($sformatf("vec%0d_turn", i),  32'(a_turn),  32'(vecs[i].eturn));
      chk($sformatf("vec%0d_count", i), 32'(a_count), 32'(vecs[i].ecount));
      chk($sformatf("vec%0d_hist", i),  32'(a_hist),  32'(vecs[i].ehist));
    end

    // Mid-game reset on A: outputs return to reset values before the next edge.
    step_a(0, 1, 18'h20, 2'd0);
    reset = 1'b1;
    #1;
    chk("midrst_a_move",  32'(a_move),  32'd0);
    chk("midrst_a_state", 32'(a_state), 32'd3);
    chk("midrst_a_turn",  32'(a_turn),  32'd1);
    chk("midrst_a_count", 32'(a_count), 32'd0);
    chk("midrst_a_hist",  32'(a_hist),  32'd0);
    reset = 1'b0;
    step_a(0, 0, 18'h0, 2'd0);
    chk("postrst_a_state", 32'(a_state), 32'd0);
    step_a(1, 0, 18'h0, 2'd0);
    chk("postrst_a_undo_move", 32'(a_move), 32'd0);
    chk("postrst_a_undo_hist", 32'(a_hist), 32'd0);

    // T6 on instance B: three-player turn rotation and undo wrap.
    do_reset();
    chk("t6_rst_state", 32'(b_state), 32'd7);
    step_b(0, 0, 32'h0, 3'd0);
    chk("t6_play", 32'(b_state), 32'd0);
    chk("t6_turn0", 32'(b_turn), 32'd1);
    step_b(0, 1, 32'h1, 3'd0);
    chk("t6_turn1", 32'(b_turn), 32'd2);
    step_b(0, 1, 32'h21, 3'd0);
    chk("t6_turn2", 32'(b_turn), 32'd3);
    step_b(0, 1, 32'h321, 3'd0);
    chk("t6_turn3", 32'(b_turn), 32'd1);
    chk("t6_count3", 32'(b_count), 32'd3);
    step_b(1, 0, 32'h0, 3'd0);
    chk("t6_undo_turn", 32'(b_turn), 32'd3);
    chk("t6_undo_move", b_move, 32'h21);
    reset = 1'b1;
    #1;
    chk("t6_midrst_state", 32'(b_state), 32'd7);
    chk("t6_midrst_move",  b_move, 32'd0);
    chk("t6_midrst_turn",  32'(b_turn), 32'd1);
    chk("t6_midrst_hist",  32'(b_hist), 32'd0);
    reset = 1'b0;

    // Randomized runs against the reference model.
    rand_run(1'b0, 400);
    rand_run(1'b1, 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
